fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the fetch stage. Generates the instruction-SRAM address every cycle.
- Tracks which PC's data is arriving from the synchronous inst SRAM (1-cycle read latency).
- Drives PC_next, IRWrite, DSI and PC_AdEL into the IF/ID register.
- Applies redirects with a fixed priority: exception > eret > stall > taken branch > sequential.

Parameters:
- RESET_ADDR, 32'hbfc00000, first fetch address after reset
- EXC_VECTOR, 32'hbfc00380, fetch address on exception flush

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hazard-unit stall; ID must hold
- id_is_branch  in  1  instruction in ID is a branch/jump (taken or not)
- id_br_taken  in  1  branch in ID resolved taken
- id_br_target  in  32  taken-branch target
- exc_flush  in  1  exception commit; redirect to EXC_VECTOR
- eret_flush  in  1  eret commit; redirect to epc
- epc  in  32  return address for eret
- inst_sram_en  out  1  SRAM enable, equals ~rst
- inst_sram_addr  out  32  word address; bits [1:0] forced to 0
- PC_next  out  32  PC of the instruction now on inst_sram_rdata
- PC_AdEL  out  1  PC_next misaligned
- IRWrite  out  1  IF/ID capture enable
- DSI  out  1  arriving instruction is a delay slot

Behaviour:
- Registers:
  - state: BOOT, RUN, HOLD
  - issue_pc: next address to present
  - fetch_pc_q: address presented in the previous cycle; drives PC_next
- While rst is high:
  - state <= BOOT; issue_pc <= RESET_ADDR; fetch_pc_q <= RESET_ADDR
  - Outputs: inst_sram_en=0, inst_sram_addr=RESET_ADDR, IRWrite=0, DSI=0, PC_AdEL=0, PC_next=RESET_ADDR
- BOOT (first cycle after reset release):
  - addr=issue_pc, IRWrite=0, stall ignored
  - Next: fetch_pc_q <= issue_pc, issue_pc <= issue_pc+4, go to RUN
- RUN/HOLD, evaluated in priority order:
  1. exc_flush (overrides stall and eret):
     - addr=EXC_VECTOR, IRWrite=0
     - fetch_pc_q <= EXC_VECTOR; issue_pc <= EXC_VECTOR+4; go to RUN
  2. eret_flush: same as exc_flush, using epc.
  3. stall:
     - addr=fetch_pc_q; the SRAM re-reads the pending word so rdata stays valid
     - IRWrite=0; registers hold; go to HOLD
  4. id_br_taken (only when not stalled):
     - addr=id_br_target, with zero bubble; IRWrite=1, which captures the delay slot
     - fetch_pc_q <= id_br_target; issue_pc <= id_br_target+4; go to RUN
  5. Otherwise:
     - addr=issue_pc, IRWrite=1
     - fetch_pc_q <= issue_pc; issue_pc <= issue_pc+4; go to RUN
- Output rules:
  - DSI = id_is_branch & IRWrite.
  - PC_AdEL = (fetch_pc_q[1:0]!=0) & state!=BOOT. A misaligned target is still issued with addr[1:0]=0, and sequential +4 continues until a flush.
  - PC adds are 32-bit and wrap modulo 2^32 with no flag.
  - exc_flush and eret_flush together: exception wins.
  - Branch and stall together: the branch is ignored and re-evaluated after the stall drops.
- Latency:
  - address to IRWrite capture is 1 cycle
  - stall release to capture is 0 cycles
  - flush to first valid capture is 1 cycle (one bubble)
- rst mid-stall or mid-flush: rst alone applies; BOOT follows.

Decomposition:
- Shared package holds:
  - RESET_ADDR and EXC_VECTOR constants
  - the 2-bit state encoding: BOOT=0, RUN=1, HOLD=2
- One combinational sub-module, fetch_pc_mux, implements the priority address select (items 1-5). The FSM and registers stay in fetch_ctrl.

Test Plan:
- Reset release:
  - cycle0: addr=bfc00000, IRWrite=0
  - cycle1: addr=bfc00004, PC_next=bfc00000, IRWrite=1
  - cycle2: PC_next=bfc00004
- Stall 3 cycles while PC_next=bfc00008:
  - addr=bfc00008 held, IRWrite=0 for 3 cycles
  - on release: IRWrite=1, PC_next=bfc00008, addr=bfc0000c
- Branch in ID with id_is_branch=1, id_br_taken=1, target=bfc00100, PC_next=bfc00010:
  - DSI=1, IRWrite=1, addr=bfc00100
  - next cycle: PC_next=bfc00100, DSI=0
- Branch with stall both asserted:
  - no redirect; addr=fetch_pc_q
  - after stall drops: addr=target
- exc_flush during stall:
  - addr=bfc00380, IRWrite=0
  - next cycle: PC_next=bfc00380, IRWrite=1
- eret_flush with epc=bfc00102:
  - addr=bfc00100
  - next cycle: PC_next=bfc00102, PC_AdEL=1

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-fetch controller.
package fetch_ctrl_pkg;

  // Default first fetch address after reset and exception vector.
  localparam logic [31:0] FETCH_RESET_ADDR = 32'hbfc0_0000;
  localparam logic [31:0] FETCH_EXC_VECTOR = 32'hbfc0_0380;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_pc_mux.sv
// Priority select of the next fetch address.
// Order: boot > exception > eret > stall > taken branch > sequential.
module fetch_pc_mux #(
  parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380
) (
  input  logic        boot,
  input  logic        exc_flush,
  input  logic        eret_flush,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] epc,
  input  logic [31:0] issue_pc,
  input  logic [31:0] fetch_pc,
  output logic [31:0] sel_pc,
  output logic        load_pc,
  output logic        ir_write,
  output logic        hold
);

  // Pick the address to present this cycle and whether the PC registers advance.
  always_comb begin
    sel_pc   = issue_pc;
    load_pc  = 1'b1;
    ir_write = 1'b0;
    hold     = 1'b0;
    if (boot) begin
      // First fetch after reset: nothing is arriving yet, stall is ignored.
      sel_pc   = issue_pc;
      ir_write = 1'b0;
    end else if (exc_flush) begin
      sel_pc   = EXC_VECTOR;
      ir_write = 1'b0;
    end else if (eret_flush) begin
      sel_pc   = epc;
      ir_write = 1'b0;
    end else if (stall) begin
      // Re-read the pending word so rdata stays valid while ID holds.
      sel_pc   = fetch_pc;
      load_pc  = 1'b0;
      hold     = 1'b1;
    end else if (br_taken) begin
      // Zero-bubble redirect; the word arriving now is the delay slot.
      sel_pc   = br_target;
      ir_write = 1'b1;
    end else begin
      sel_pc   = issue_pc;
      ir_write = 1'b1;
    end
  end

endmodule : fetch_pc_mux

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives the instruction SRAM address every cycle and
// tracks which PC's data is arriving on the 1-cycle-latency read port.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = FETCH_RESET_ADDR,
  parameter logic [31:0] EXC_VECTOR = FETCH_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        id_is_branch,
  input  logic        id_br_taken,
  input  logic [31:0] id_br_target,
  input  logic        exc_flush,
  input  logic        eret_flush,
  input  logic [31:0] epc,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] PC_next,
  output logic        PC_AdEL,
  output logic        IRWrite,
  output logic        DSI
);

  fetch_state_e state_reg;
  fetch_state_e state_next;
  logic [31:0]  issue_pc_reg;
  logic [31:0]  fetch_pc_reg;

  logic [31:0]  sel_pc;
  logic         load_pc;
  logic         ir_write;
  logic         hold;
  logic         boot;

  assign boot = (state_reg == ST_BOOT);

  fetch_pc_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_mux (
    .boot       (boot),
    .exc_flush  (exc_flush),
    .eret_flush (eret_flush),
    .stall      (stall),
    .br_taken   (id_br_taken),
    .br_target  (id_br_target),
    .epc        (epc),
    .issue_pc   (issue_pc_reg),
    .fetch_pc   (fetch_pc_reg),
    .sel_pc     (sel_pc),
    .load_pc    (load_pc),
    .ir_write   (ir_write),
    .hold       (hold)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: BOOT always moves on; a non-flushed stall parks in HOLD.
  always_comb begin
    state_next = state_reg;
    if (boot) begin
      state_next = ST_RUN;
    end else if (hold) begin
      state_next = ST_HOLD;
    end else begin
      state_next = ST_RUN;
    end
  end

  // PC registers: the presented address becomes the arriving PC next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_pc_reg <= RESET_ADDR;
      fetch_pc_reg <= RESET_ADDR;
    end else if (load_pc) begin
      fetch_pc_reg <= sel_pc;
      issue_pc_reg <= sel_pc + 32'd4;
    end
  end

  // Outputs; reset forces quiet values regardless of register contents.
  always_comb begin
    inst_sram_en   = ~rst;
    inst_sram_addr = rst ? {RESET_ADDR[31:2], 2'b00} : {sel_pc[31:2], 2'b00};
    PC_next        = rst ? RESET_ADDR : fetch_pc_reg;
    IRWrite        = ~rst & ir_write;
    DSI            = id_is_branch & IRWrite;
    PC_AdEL        = ~rst & ~boot & (fetch_pc_reg[1:0] != 2'b00);
  end

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Directed test of the fetch controller with hand-computed expectations.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        id_is_branch;
  logic        id_br_taken;
  logic [31:0] id_br_target;
  logic        exc_flush;
  logic        eret_flush;
  logic [31:0] epc;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] PC_next;
  logic        PC_AdEL;
  logic        IRWrite;
  logic        DSI;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .id_is_branch   (id_is_branch),
    .id_br_taken    (id_br_taken),
    .id_br_target   (id_br_target),
    .exc_flush      (exc_flush),
    .eret_flush     (eret_flush),
    .epc            (epc),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr),
    .PC_next        (PC_next),
    .PC_AdEL        (PC_AdEL),
    .IRWrite        (IRWrite),
    .DSI            (DSI)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Sample mid-cycle, away from the active edge.
  task automatic settle();
    #3;
    $display("cyc %0d: rst=%0b stall=%0b addr=%08h PC_next=%08h IRWrite=%0b DSI=%0b AdEL=%0b",
             cyc, rst, stall, inst_sram_addr, PC_next, IRWrite, DSI, PC_AdEL);
  endtask

  task automatic clear_inputs();
    stall        = 1'b0;
    id_is_branch = 1'b0;
    id_br_taken  = 1'b0;
    id_br_target = 32'h0;
    exc_flush    = 1'b0;
    eret_flush   = 1'b0;
    epc          = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    settle();
    check("rst_en",     {31'd0, inst_sram_en}, 32'd0);
    check("rst_addr",   inst_sram_addr, 32'hbfc00000);
    check("rst_irw",    {31'd0, IRWrite}, 32'd0);
    check("rst_pcnext", PC_next, 32'hbfc00000);
    check("rst_dsi",    {31'd0, DSI}, 32'd0);
    check("rst_adel",   {31'd0, PC_AdEL}, 32'd0);

    // Reset release: BOOT cycle
    next_cycle(); rst = 1'b0; settle();
    check("boot_en",   {31'd0, inst_sram_en}, 32'd1);
    check("boot_addr", inst_sram_addr, 32'hbfc00000);
    check("boot_irw",  {31'd0, IRWrite}, 32'd0);

    next_cycle(); settle();
    check("c1_addr",   inst_sram_addr, 32'hbfc00004);
    check("c1_pcnext", PC_next, 32'hbfc00000);
    check("c1_irw",    {31'd0, IRWrite}, 32'd1);

    next_cycle(); settle();
    check("c2_pcnext", PC_next, 32'hbfc00004);
    check("c2_addr",   inst_sram_addr, 32'hbfc00008);

    // Stall for 3 cycles while PC_next = bfc00008
    for (int i = 0; i < 3; i++) begin
      next_cycle(); stall = 1'b1; settle();
      check("stall_pcnext", PC_next, 32'hbfc00008);
      check("stall_addr",   inst_sram_addr, 32'hbfc00008);
      check("stall_irw",    {31'd0, IRWrite}, 32'd0);
    end
    next_cycle(); stall = 1'b0; settle();
    check("rel_irw",    {31'd0, IRWrite}, 32'd1);
    check("rel_pcnext", PC_next, 32'hbfc00008);
    check("rel_addr",   inst_sram_addr, 32'hbfc0000c);

    next_cycle(); settle();
    check("seq_pcnext", PC_next, 32'hbfc0000c);

    // Taken branch in ID while PC_next = bfc00010
    next_cycle();
    id_is_branch = 1'b1; id_br_taken = 1'b1; id_br_target = 32'hbfc00100;
    settle();
    check("br_pcnext", PC_next, 32'hbfc00010);
    check("br_dsi",    {31'd0, DSI}, 32'd1);
    check("br_irw",    {31'd0, IRWrite}, 32'd1);
    check("br_addr",   inst_sram_addr, 32'hbfc00100);

    next_cycle(); clear_inputs(); settle();
    check("br1_pcnext", PC_next, 32'hbfc00100);
    check("br1_dsi",    {31'd0, DSI}, 32'd0);
    check("br1_addr",   inst_sram_addr, 32'hbfc00104);

    // Branch and stall together: stall wins, branch re-evaluated after
    next_cycle();
    id_is_branch = 1'b1; id_br_taken = 1'b1; id_br_target = 32'hbfc00200; stall = 1'b1;
    settle();
    check("brst_addr", inst_sram_addr, 32'hbfc00104);
    check("brst_irw",  {31'd0, IRWrite}, 32'd0);
    check("brst_dsi",  {31'd0, DSI}, 32'd0);

    next_cycle(); stall = 1'b0; settle();
    check("brrel_addr",   inst_sram_addr, 32'hbfc00200);
    check("brrel_pcnext", PC_next, 32'hbfc00104);
    check("brrel_dsi",    {31'd0, DSI}, 32'd1);

    // Exception during stall, with eret also asserted: exception wins
    next_cycle();
    clear_inputs();
    stall = 1'b1; exc_flush = 1'b1; eret_flush = 1'b1; epc = 32'hbfc00102;
    settle();
    check("exc_addr", inst_sram_addr, 32'hbfc00380);
    check("exc_irw",  {31'd0, IRWrite}, 32'd0);

    next_cycle(); clear_inputs(); settle();
    check("exc1_pcnext", PC_next, 32'hbfc00380);
    check("exc1_irw",    {31'd0, IRWrite}, 32'd1);
    check("exc1_addr",   inst_sram_addr, 32'hbfc00384);

    // eret to a misaligned epc
    next_cycle(); eret_flush = 1'b1; epc = 32'hbfc00102; settle();
    check("eret_addr", inst_sram_addr, 32'hbfc00100);
    check("eret_irw",  {31'd0, IRWrite}, 32'd0);
    check("eret_adel", {31'd0, PC_AdEL}, 32'd0);

    next_cycle(); clear_inputs(); settle();
    check("eret1_pcnext", PC_next, 32'hbfc00102);
    check("eret1_adel",   {31'd0, PC_AdEL}, 32'd1);
    check("eret1_addr",   inst_sram_addr, 32'hbfc00104);

    // Misaligned sequence continues; branch to top of address space
    next_cycle(); id_br_taken = 1'b1; id_br_target = 32'hfffffffc; settle();
    check("mis_pcnext", PC_next, 32'hbfc00106);
    check("mis_adel",   {31'd0, PC_AdEL}, 32'd1);
    check("wrap_addr",  inst_sram_addr, 32'hfffffffc);
    check("wrap_dsi",   {31'd0, DSI}, 32'd0);

    next_cycle(); clear_inputs(); settle();
    check("wrap1_pcnext", PC_next, 32'hfffffffc);
    check("wrap1_adel",   {31'd0, PC_AdEL}, 32'd0);
    check("wrap1_addr",   inst_sram_addr, 32'h00000000);

    next_cycle(); settle();
    check("wrap2_pcnext", PC_next, 32'h00000000);
    check("wrap2_addr",   inst_sram_addr, 32'h00000004);

    // Reset asserted mid-stall
    next_cycle(); rst = 1'b1; stall = 1'b1; settle();
    check("rst2_en",     {31'd0, inst_sram_en}, 32'd0);
    check("rst2_addr",   inst_sram_addr, 32'hbfc00000);
    check("rst2_pcnext", PC_next, 32'hbfc00000);
    check("rst2_irw",    {31'd0, IRWrite}, 32'd0);

    // BOOT ignores stall
    next_cycle(); rst = 1'b0; settle();
    check("boot2_addr", inst_sram_addr, 32'hbfc00000);
    check("boot2_irw",  {31'd0, IRWrite}, 32'd0);

    next_cycle(); settle();
    check("boot2st_pcnext", PC_next, 32'hbfc00000);
    check("boot2st_addr",   inst_sram_addr, 32'hbfc00000);
    check("boot2st_irw",    {31'd0, IRWrite}, 32'd0);

    next_cycle(); stall = 1'b0; settle();
    check("boot2rel_irw",  {31'd0, IRWrite}, 32'd1);
    check("boot2rel_addr", inst_sram_addr, 32'hbfc00004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_ctrl
